// File: rtl/fire_sched_pkg.sv
// Shared types and width helpers for the fire squeeze layer scheduler.
package fire_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    // Counter width for a value range 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sched_delay_line.sv
// Fixed-depth 1-bit shift register; output is the input delayed DEPTH cycles.
module sched_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [DEPTH-1:0] r_sh;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_sh <= '0;
                else     r_sh <= i_d;
            end
        end else begin : g_multi
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_sh <= '0;
                else     r_sh <= {r_sh[DEPTH-2:0], i_d};
            end
        end
    endgenerate

    assign o_q = r_sh[DEPTH-1];

endmodule

// File: rtl/fire_squeeze_sched.sv
// Issue sequencer for one 1x1 squeeze layer: pixel/channel address walk, MAC clear and ofm write alignment.
// Optional macro FIRE_SQUEEZE_STALL_CNT_EN adds the stall_cycles counter output.
module fire_squeeze_sched
    import fire_sched_pkg::*;
#(
    parameter int WOUT     = 32,
    parameter int CHIN     = 256,
    parameter int DSP_NO   = 32,
    parameter int PIPE_LAT = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 stall,
    input  logic                                 ram_feedback,
    output logic                                 layer_en,
    output logic [cnt_w(WOUT*WOUT*CHIN)-1:0]     ifm_rd_addr,
    output logic [cnt_w(CHIN)-1:0]               weight_addr,
    output logic                                 clr,
    output logic                                 ofm_wr_en,
    output logic [cnt_w(WOUT*WOUT)-1:0]          ofm_wr_addr,
    output logic                                 busy,
    output logic                                 done
`ifdef FIRE_SQUEEZE_STALL_CNT_EN
    ,
    output logic [31:0]                          stall_cycles
`endif
);

    localparam int PIX = WOUT * WOUT;
    localparam int AW  = cnt_w(PIX * CHIN);
    localparam int CW  = cnt_w(CHIN);
    localparam int PW  = cnt_w(PIX);
    localparam int DW  = cnt_w(PIPE_LAT + 1);

    generate
        if (WOUT < 1 || CHIN < 2 || DSP_NO < 1 || PIPE_LAT < 1) begin : g_bad_params
            $error("fire_squeeze_sched: unsupported parameter set");
        end
    endgenerate

    sched_state_t    r_state;
    sched_state_t    w_next;
    logic [CW-1:0]   r_ch;
    logic [PW-1:0]   r_pix;
    logic [DW-1:0]   r_drain_cnt;
    logic            r_fb_seen;
    logic            r_layer_en;
    logic [AW-1:0]   r_ifm_addr;
    logic [CW-1:0]   r_w_addr;
    logic [PW-1:0]   r_ofm_addr;
    logic            w_issue;
    logic            w_ch_last;
    logic            w_pix_last;
    logic            w_last_tok;
    logic            w_clr;
    logic            w_wr_en;

    assign w_issue    = (r_state == RUN) && !stall;
    assign w_ch_last  = (r_ch == CW'(CHIN - 1));
    assign w_pix_last = (r_pix == PW'(PIX - 1));
    assign w_last_tok = w_issue && w_ch_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_last_tok && w_pix_last) w_next = DRAIN;
            DRAIN:   if (r_drain_cnt == DW'(PIPE_LAT)) w_next = DONE;
            DONE:    if (ram_feedback || r_fb_seen) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ch        <= '0;
            r_pix       <= '0;
            r_drain_cnt <= '0;
            r_fb_seen   <= 1'b0;
            r_layer_en  <= 1'b0;
            r_ifm_addr  <= '0;
            r_w_addr    <= '0;
            r_ofm_addr  <= '0;
        end else begin
            r_layer_en <= w_issue;
            if (r_state == IDLE && start) begin
                r_ch       <= '0;
                r_pix      <= '0;
                r_ofm_addr <= '0;
            end else begin
                if (w_issue) begin
                    r_ifm_addr <= AW'(r_pix) * AW'(CHIN) + AW'(r_ch);
                    r_w_addr   <= r_ch;
                    if (w_ch_last) begin
                        r_ch  <= '0;
                        r_pix <= w_pix_last ? '0 : r_pix + 1'b1;
                    end else begin
                        r_ch <= r_ch + 1'b1;
                    end
                end
                if (w_wr_en)
                    r_ofm_addr <= (r_ofm_addr == PW'(PIX - 1)) ? '0 : r_ofm_addr + 1'b1;
            end
            r_drain_cnt <= (r_state == DRAIN) ? r_drain_cnt + 1'b1 : '0;
            // An early ack is remembered so DONE collapses to a single cycle.
            if ((r_state == RUN || r_state == DRAIN) && ram_feedback)
                r_fb_seen <= 1'b1;
            else if (r_state == DONE && w_next == IDLE)
                r_fb_seen <= 1'b0;
        end
    end

    // Last-channel token reaches the accumulator PIPE_LAT cycles after its issue edge.
    sched_delay_line #(.DEPTH(PIPE_LAT + 1)) u_clr_dly (
        .clk (clk),
        .rst (rst),
        .i_d (w_last_tok),
        .o_q (w_clr)
    );

    sched_delay_line #(.DEPTH(1)) u_wr_dly (
        .clk (clk),
        .rst (rst),
        .i_d (w_clr),
        .o_q (w_wr_en)
    );

`ifdef FIRE_SQUEEZE_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (r_state == IDLE && start)
            r_stall_cnt <= '0;
        else if (r_state == RUN && stall && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    assign stall_cycles = r_stall_cnt;
`endif

    assign layer_en    = r_layer_en;
    assign ifm_rd_addr = r_ifm_addr;
    assign weight_addr = r_w_addr;
    assign clr         = w_clr;
    assign ofm_wr_en   = w_wr_en;
    assign ofm_wr_addr = r_ofm_addr;
    assign busy        = (r_state != IDLE);
    assign done        = (r_state == DONE);

endmodule

// File: tb/tb_fire_squeeze_sched.sv
// Directed bench for fire_squeeze_sched at WOUT=2, CHIN=4, PIPE_LAT=2.
module tb_fire_squeeze_sched;

  localparam int WOUT     = 2;
  localparam int CHIN     = 4;
  localparam int DSP_NO   = 32;
  localparam int PIPE_LAT = 2;
  localparam int PIX      = WOUT * WOUT;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stall;
  logic       ram_feedback;
  logic       layer_en;
  logic [3:0] ifm_rd_addr;
  logic [1:0] weight_addr;
  logic       clr;
  logic       ofm_wr_en;
  logic [1:0] ofm_wr_addr;
  logic       busy;
  logic       done;
`ifdef FIRE_SQUEEZE_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  fire_squeeze_sched #(
    .WOUT     (WOUT),
    .CHIN     (CHIN),
    .DSP_NO   (DSP_NO),
    .PIPE_LAT (PIPE_LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stall        (stall),
    .ram_feedback (ram_feedback),
    .layer_en     (layer_en),
    .ifm_rd_addr  (ifm_rd_addr),
    .weight_addr  (weight_addr),
    .clr          (clr),
    .ofm_wr_en    (ofm_wr_en),
    .ofm_wr_addr  (ofm_wr_addr),
    .busy         (busy),
`ifdef FIRE_SQUEEZE_STALL_CNT_EN
    .done         (done),
    .stall_cycles (stall_cycles)
`else
    .done         (done)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_layer_en"}, layer_en, 0);
    check({tag, "_ifm_addr"}, ifm_rd_addr, 0);
    check({tag, "_w_addr"}, weight_addr, 0);
    check({tag, "_clr"}, clr, 0);
    check({tag, "_wr_en"}, ofm_wr_en, 0);
    check({tag, "_wr_addr"}, ofm_wr_addr, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // One layer; n counts edges after the one that samples start.
  task automatic run_layer(input string tag, input int s1_pos, input int s1_len,
                           input int s2_pos, input int s2_len, input int fb_n,
                           input int run_start_n, input int exp_done_n, input bit start_in_done);
    int n, s1_left, s2_left, en_cnt, clr_idx, wr_idx, done_n, exp_clr;
    bit s1_hit, s2_hit, stalled;
    int clr_n[PIX];
    logic [3:0] last_issued, e;
    exp_q.delete();
    for (int a = 0; a < PIX * CHIN; a++) exp_q.push_back(4'(a));
    s1_left = 0; s2_left = 0; en_cnt = 0; clr_idx = 0; wr_idx = 0; done_n = 0;
    s1_hit = 0; s2_hit = 0; last_issued = 0;
    for (int p = 0; p < PIX; p++) clr_n[p] = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    check({tag, "_busy_after_start"}, busy, 1);
`ifdef FIRE_SQUEEZE_STALL_CNT_EN
    check({tag, "_stallcnt_cleared"}, stall_cycles, 0);
`endif
    while (n < 80 && done_n == 0) begin
      stalled = (s1_left > 0) || (s2_left > 0);
      stall = stalled;
      ram_feedback = (n + 1 == fb_n);
      start = (n + 1 == run_start_n);
      step();
      n++;
      stall = 1'b0; ram_feedback = 1'b0; start = 1'b0;
      if (stalled) begin
        if (s1_left > 0) s1_left--; else s2_left--;
        check({tag, "_stall_en_low"}, layer_en, 0);
        check({tag, "_stall_addr_hold"}, ifm_rd_addr, last_issued);
      end
      if (layer_en) begin
        en_cnt++;
        if (exp_q.size() == 0) begin
          check({tag, "_extra_issue"}, 1, 0);
        end else begin
          e = exp_q.pop_front();
          check({tag, "_ifm_addr"}, ifm_rd_addr, e);
          check({tag, "_weight_addr"}, weight_addr, e[1:0]);
          last_issued = e;
          if (!s1_hit && s1_len > 0 && int'(e) == s1_pos) begin s1_hit = 1; s1_left = s1_len; end
          if (!s2_hit && s2_len > 0 && int'(e) == s2_pos) begin s2_hit = 1; s2_left = s2_len; end
        end
      end
      if (clr) begin
        if (clr_idx < PIX) clr_n[clr_idx] = n;
        clr_idx++;
      end
      if (ofm_wr_en) begin
        if (wr_idx < PIX) check({tag, "_wr_after_clr"}, n - 1, clr_n[wr_idx]);
        check({tag, "_ofm_wr_addr"}, ofm_wr_addr, wr_idx[1:0]);
        wr_idx++;
      end
      if (done) done_n = n;
    end
    if (done_n == 0) check({tag, "_done_timeout"}, 0, 1);
    else check({tag, "_done_latency"}, done_n, exp_done_n);
    check({tag, "_issue_count"}, en_cnt, PIX * CHIN);
    check({tag, "_clr_count"}, clr_idx, PIX);
    check({tag, "_wr_count"}, wr_idx, PIX);
    check({tag, "_en_low_at_done"}, layer_en, 0);
    // Last channel of pixel p issues at n = CHIN*p+CHIN+1, shifted by any earlier stall window.
    for (int p = 0; p < PIX; p++) begin
      exp_clr = CHIN * p + CHIN + 1 + PIPE_LAT;
      if (s1_len > 0 && s1_pos < CHIN * p + CHIN - 1) exp_clr += s1_len;
      if (s2_len > 0 && s2_pos < CHIN * p + CHIN - 1) exp_clr += s2_len;
      check({tag, "_clr_time"}, clr_n[p], exp_clr);
    end
`ifdef FIRE_SQUEEZE_STALL_CNT_EN
    check({tag, "_stall_cycles"}, stall_cycles, s1_len + s2_len);
`endif
    if (fb_n > 0) begin
      start = start_in_done;
      step();
      start = 1'b0;
      check({tag, "_done_one_cycle"}, done, 0);
      check({tag, "_idle_after_ack"}, busy, 0);
      step();
      check({tag, "_no_restart"}, busy, 0);
    end else begin
      start = start_in_done;
      step();
      start = 1'b0;
      check({tag, "_done_hold1"}, done, 1);
      step();
      step();
      check({tag, "_done_hold3"}, done, 1);
      ram_feedback = 1'b1;
      step();
      ram_feedback = 1'b0;
      check({tag, "_done_cleared"}, done, 0);
      check({tag, "_idle_after_ack"}, busy, 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; ram_feedback = 1'b0;
    #2;
    check_all_zero("reset");
    step();
    step();
    rst = 1'b0;
    step();
    check_all_zero("post_reset_idle");

    run_layer("plain",      0, 0,  0, 0,  0, 0, 20, 1'b1);
    run_layer("stall3",     5, 3,  0, 0,  0, 0, 23, 1'b0);
    run_layer("fb_in_run",  0, 0,  0, 0, 10, 0, 20, 1'b1);
    run_layer("start_run",  0, 0,  0, 0,  0, 8, 20, 1'b0);

    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (layer_en && ifm_rd_addr == 4'd9) break;
    end
    check("midrun_reached_addr9", ifm_rd_addr, 9);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    step();
    step();
    rst = 1'b0;
    step();
    step();
    check_all_zero("after_midrun_reset");

    run_layer("after_reset", 0, 0,  0, 0,  0, 0, 20, 1'b0);
    run_layer("stall3p2",    5, 3, 12, 2,  0, 0, 25, 1'b0);
    run_layer("clean_again", 0, 0,  0, 0,  0, 0, 20, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
